// File: rtl/uart_tx_sched.sv
// uart_tx_sched: per-message round-robin sharing of one 8N1 UART transmitter.
// Define UART_TX_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int HOLD_TO = 2500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_en,
  input  logic               tx_rfn,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_TO > 1) ? $clog2(HOLD_TO) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TO - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             lock_q, lock_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [CW-1:0]    hcnt_q, hcnt_d;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic             do_acc;
  logic             drop;
  logic [IW-1:0]    acc_idx;
  logic             tmo;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_vld = |req_valid;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win_idx = IW'(i);
    end
  end
`else
  logic [IW-1:0] last_gnt_q, last_gnt_d;
  logic [IW-1:0] cand;

  // Search starts one past the last winner and wraps.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_gnt_q) + k) % N_REQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (do_acc) last_gnt_d = acc_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) last_gnt_q <= IW'(N_REQ - 1);
    else     last_gnt_q <= last_gnt_d;
  end
`endif

  assign tmo = (HOLD_TO != 0) && (hcnt_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ready_q <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      gidx_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
      gidx_q  <= gidx_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    do_acc  = 1'b0;
    drop    = 1'b0;
    acc_idx = gidx_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_rfn && win_vld) begin
          do_acc  = 1'b1;
          acc_idx = win_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!tx_rfn) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (tx_rfn) begin
          if (!lock_q) begin
            drop    = 1'b1;
            state_d = S_IDLE;
          end else if (req_valid[gidx_q]) begin
            do_acc  = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (req_valid[gidx_q]) begin
          do_acc  = 1'b1;
          state_d = S_LAUNCH;
        end else if (tmo) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    ready_d = '0;
    data_d  = data_q;
    lock_d  = lock_q;
    gidx_d  = gidx_q;
    hcnt_d  = '0;
    if (state_q == S_HOLD && state_d == S_HOLD) begin
      hcnt_d = hcnt_q + CW'(1);
    end
    if (do_acc) begin
      ready_d = ONE << acc_idx;
      grant_d = ONE << acc_idx;
      data_d  = req_data[{acc_idx, 3'b000} +: 8];
      lock_d  = ~req_last[acc_idx];
      gidx_d  = acc_idx;
    end
    // Dropping ownership also ends any abandoned message.
    if (drop) begin
      grant_d = '0;
      lock_d  = 1'b0;
    end
    en_d   = (state_d == S_LAUNCH);
    busy_d = (state_d != S_IDLE);
  end

  assign req_ready = ready_q;
  assign grant     = grant_q;
  assign tx_data   = data_q;
  assign tx_en     = en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched
// against a message-level queue model and a latency-2 transmitter model.
module tb_uart_tx_sched;

  localparam int N_REQ   = 4;
  localparam int HOLD_TO = 16;
  localparam int TXF     = 20;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_last = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         tx_data;
  logic               tx_en;
  logic               tx_rfn = 1'b1;
  logic               busy;

  logic tx_enq = 1'b0;
  int   tx_cnt = 0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [8:0] rq [N_REQ][$];
  int         acc_idx_q[$];
  logic [7:0] acc_dat_q[$];
  logic [7:0] launch_q[$];
  int         exp_idx_q[$];
  logic [7:0] exp_dat_q[$];

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N_REQ  (N_REQ),
    .HOLD_TO(HOLD_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_rfn   (tx_rfn),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter: registers tx_en, starts a frame one edge later.
  always @(posedge clk) begin
    tx_enq <= tx_en;
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_rfn <= 1'b1;
    end else if (tx_rfn && tx_enq) begin
      tx_rfn <= 1'b0;
      tx_cnt <= TXF;
      launch_q.push_back(tx_data);
    end
  end

  // Requesters present their queue head; pop on req_ready.
  always @(negedge clk) begin
    logic [N_REQ-1:0]   v;
    logic [N_REQ-1:0]   l;
    logic [8*N_REQ-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        v[i]       = 1'b1;
        l[i]       = rq[i][0][8];
        d[8*i +: 8] = rq[i][0][7:0];
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  end

  always @(negedge clk) begin
    int idx;
    if (req_ready != '0) begin
      idx = 0;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) idx = i;
      chk("ready_onehot", 32'($onehot(req_ready)), 1);
      chk("grant_eq_ready", grant, req_ready);
      acc_idx_q.push_back(idx);
      acc_dat_q.push_back(tx_data);
    end
  end

  // Message-level model: whole messages, served in arbitration order.
  task automatic build_exp();
    logic [8:0] mq [N_REQ][$];
    logic [8:0] b;
    int         w;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    int         cur;
    cur = N_REQ - 1;
`endif
    exp_idx_q.delete();
    exp_dat_q.delete();
    for (int i = 0; i < N_REQ; i++) mq[i] = rq[i];
    forever begin
      w = -1;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      for (int j = N_REQ - 1; j >= 0; j--) if (mq[j].size() > 0) w = j;
`else
      for (int k = 1; k <= N_REQ; k++) begin
        int j;
        j = (cur + k) % N_REQ;
        if (w < 0 && mq[j].size() > 0) w = j;
      end
`endif
      if (w < 0) break;
      do begin
        b = mq[w].pop_front();
        exp_idx_q.push_back(w);
        exp_dat_q.push_back(b[7:0]);
      end while (!b[8] && mq[w].size() > 0);
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      cur = w;
`endif
    end
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic wait_rfn(input logic v, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_rfn === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_rfn && !busy && !tx_en) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_before_reset", 32'(ok), 1);
    for (int i = 0; i < N_REQ; i++) rq[i].delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_idx_q.delete();
    acc_dat_q.delete();
    launch_q.delete();
  endtask

  task automatic run_stream(input string tag);
    bit ok;
    int n;
    build_exp();
    ok = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (launch_q.size() >= exp_idx_q.size() && tx_rfn && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(ok), 1);
    chk({tag, "_nacc"}, acc_idx_q.size(), exp_idx_q.size());
    chk({tag, "_nlaunch"}, launch_q.size(), exp_idx_q.size());
    n = exp_idx_q.size();
    if (acc_idx_q.size() < n) n = acc_idx_q.size();
    if (launch_q.size() < n) n = launch_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_idx%0d", tag, i), acc_idx_q[i], exp_idx_q[i]);
      chk($sformatf("%s_dat%0d", tag, i), acc_dat_q[i], exp_dat_q[i]);
      chk($sformatf("%s_tx%0d", tag, i), launch_q[i], exp_dat_q[i]);
    end
  endtask

  initial begin
    int n;
    int n0;
    bit ok;
    int len;
    int nm;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single requester, one-byte message
    do_reset();
    rq[2].push_back({1'b1, 8'hA5});
    wait_ready(n);
    chk("t1_acc_seen", 32'(n > 0), 1);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_en", tx_en, 1);
    chk("t1_grant", grant, 4'b0100);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_ready_pulse", req_ready, 0);
    wait_rfn(1'b0, ok);
    chk("t1_rfn_fall", 32'(ok), 1);
    chk("t1_en_at_fall", tx_en, 1);
    @(negedge clk);
    chk("t1_en_drop", tx_en, 0);
    wait_rfn(1'b1, ok);
    chk("t1_rfn_rise", 32'(ok), 1);
    chk("t1_grant_held", grant, 4'b0100);
    @(negedge clk);
    chk("t1_grant_clr", grant, 0);
    chk("t1_idle", busy, 0);
    repeat (5) @(negedge clk);
    chk("t1_nacc", acc_idx_q.size(), 1);
    chk("t1_nlaunch", launch_q.size(), 1);
    if (launch_q.size() > 0) chk("t1_tx_byte", launch_q[0], 8'hA5);

    // Contention, requesters 0,1,3 with one-byte messages
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N_REQ; i++)
        if (i != 2) rq[i].push_back({1'b1, 8'(16 * i + k)});
    run_stream("t2");

    // Locked three-byte message against a busy requester 0
    do_reset();
    rq[1].push_back({1'b0, 8'h01});
    rq[1].push_back({1'b0, 8'h02});
    rq[1].push_back({1'b1, 8'h03});
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hA1});
    run_stream("t3");

    // HOLD timeout after an abandoned message
    do_reset();
    rq[2].push_back({1'b0, 8'h77});
    rq[3].push_back({1'b1, 8'h33});
    wait_ready(n);
    chk("t4_first", req_ready, 4'b0100);
    chk("t4_first_dat", tx_data, 8'h77);
    wait_rfn(1'b0, ok);
    chk("t4_rfn_fall", 32'(ok), 1);
    wait_rfn(1'b1, ok);
    chk("t4_rfn_rise", 32'(ok), 1);
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (grant == '0) begin
        n = c;
        break;
      end
    end
    chk("t4_hold_cycles", n, HOLD_TO + 1);
    chk("t4_no_acc_in_hold", acc_idx_q.size(), 1);
    wait_ready(n);
    chk("t4_next_lat", n, 1);
    chk("t4_next", req_ready, 4'b1000);
    chk("t4_next_dat", tx_data, 8'h33);

    // Reset while the transmitter is mid-frame
    do_reset();
    rq[0].push_back({1'b1, 8'h11});
    rq[0].push_back({1'b1, 8'h22});
    wait_ready(n);
    chk("t5_first_dat", tx_data, 8'h11);
    wait_rfn(1'b0, ok);
    chk("t5_in_frame", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_en_off", tx_en, 0);
    chk("t5_grant_off", grant, 0);
    chk("t5_busy_off", busy, 0);
    chk("t5_rfn_still_low", tx_rfn, 0);
    n0 = acc_idx_q.size();
    wait_rfn(1'b1, ok);
    chk("t5_rfn_rise", 32'(ok), 1);
    chk("t5_no_early_acc", acc_idx_q.size(), n0);
    wait_ready(n);
    chk("t5_relaunch_lat", n, 1);
    chk("t5_relaunch", req_ready, 4'b0001);
    chk("t5_relaunch_dat", tx_data, 8'h22);
    wait_rfn(1'b0, ok);
    wait_rfn(1'b1, ok);
    repeat (3) @(negedge clk);
    chk("t5_nlaunch", launch_q.size(), 2);

    // Requesters 1 and 2 held continuously
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rq[1].push_back({1'b1, 8'h10 + 8'(k)});
      rq[2].push_back({1'b1, 8'h20 + 8'(k)});
    end
    run_stream("t6");

    // Random messages on random requesters
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N_REQ; i++) begin
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            rq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      run_stream($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one 8N1 UART transmitter (CPB-timed, `Tx_EN`/`RFN` handshake) between `N_REQ` byte-stream requesters. It sits between the application-side message sources and the transmitter. It arbitrates per message, so a granted requester keeps the line until its byte flagged `last` is accepted. It also sequences the transmitter's enable/ready handshake so that every byte is launched exactly once.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `HOLD_TO`, 2500 — cycles a locked requester may stall mid-message before its lock is released; 0 disables the timeout.
- `clk`  in  1 — system clock, single clock domain.
- `rst`  in  1 — synchronous, active-high reset.
- `req_valid`  in  N_REQ — requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  in  8·N_REQ — packed bytes, requester 0 in the LSBs.
- `req_last`  in  N_REQ — the byte is the final byte of its message.
- `req_ready`  out  N_REQ — one-cycle pulse: requester i's byte was accepted.
- `grant`  out  N_REQ — one-hot owner of the transmitter; 0 when unowned.
- `tx_data`  out  8 — byte to the transmitter; held stable until the next accept.
- `tx_en`  out  1 — transmit enable to the transmitter.
- `tx_rfn`  in  1 — transmitter ready-for-next (high = idle).
- `busy`  out  1 — high in any state other than IDLE.

## Operation
- States: IDLE, LAUNCH, BUSY, HOLD.
- **IDLE**
  - Arbitrates only while `tx_rfn`=1.
  - The winner is the first asserted `req_valid` searching from `last_gnt+1` upward, with wrap-around.
  - Accept actions:
    - latch `req_data` into `tx_data`;
    - pulse `req_ready`;
    - set `grant`;
    - update `last_gnt`;
    - set `lock` = !`req_last`;
    - go to LAUNCH.
- **LAUNCH**
  - `tx_en`=1.
  - Stays until `tx_rfn`=0 is sampled.
  - Then `tx_en` is 0 from the next cycle and the state goes to BUSY.
- **BUSY**
  - Waits for `tx_rfn`=1.
  - Then, if !`lock`: clear `grant` and go to IDLE. Arbitration happens in IDLE, at least one cycle later.
  - If `lock` and the granted requester has `req_valid`=1: accept its byte (same accept actions as IDLE, `lock` from `req_last`) and go to LAUNCH.
  - If `lock` and that requester has `req_valid`=0: go to HOLD.
- **HOLD**
  - Only the granted requester is observed; others are ignored.
  - On its `req_valid`: accept and go to LAUNCH.
  - A counter counts HOLD cycles. When it reaches `HOLD_TO`-1 (and `HOLD_TO`≠0): clear `lock` and `grant`, go to IDLE. The dropped message is the requester's problem, and no `req_ready` is issued.
- Accept rules:
  - At most one `req_ready` bit per cycle.
  - Never two accepts without an intervening `tx_rfn` low→high pair.
- `req_data` and `req_last` are sampled only in the accept cycle.
- A one-byte message (`last`=1 on its first byte) never locks.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `tx_en`=0, `tx_data`=8'h00, `busy`=0, `last_gnt`=N_REQ-1 (so requester 0 wins first), `lock`=0, hold counter 0, state IDLE.
- `rst` mid-operation returns to IDLE on the next edge and deasserts `tx_en`. The transmitter is not reset. The IDLE rule (`tx_rfn`=1 required) blocks a relaunch until any in-flight frame finishes.
- Accept at edge k:
  - `tx_en`, `tx_data`, `grant` and `req_ready` are visible after edge k.
  - The transmitter sees `tx_en` at edge k+1 and drops `tx_rfn` after edge k+2.
  - LAUNCH therefore lasts ≥2 cycles.
- All outputs are registered; there are no combinational input→output paths.
- Per-byte overhead beyond the transmitter frame is ≤4 cycles.

## Configuration
- `UART_TX_SCHED_FIXED_PRIO_EN` defined: round-robin is replaced by fixed priority, where the lowest asserted index wins. `last_gnt` is neither updated nor used. Message locking and HOLD are unchanged.
- Not defined: round-robin as described above.

## Test plan
- Single requester: `req_valid[2]`=1, `req_data`=8'hA5, `last`=1 → one `req_ready[2]` pulse, `tx_data`=8'hA5, `tx_en` high until `tx_rfn` falls, `grant` 0 after `tx_rfn` rises.
- Contention: `req_valid`=4'b1011, all `last`=1, held continuously → accept order 0,1,3,0,…, exactly one byte per `tx_rfn` cycle.
- Lock: requester 1 sends 3 bytes (8'h01, 02, 03, `last` on 03) while requester 0 is valid throughout → bytes 01,02,03 are transmitted consecutively, then requester 0.
- HOLD timeout: `HOLD_TO`=16, requester 2 sends one non-last byte then drops `req_valid` → `grant`=0 exactly 16 HOLD cycles later; the next requester is then served.
- Reset mid-frame: assert `rst` one cycle while the transmitter is in frame (`tx_rfn`=0) with requester 0 valid → `tx_en`=0; no accept until `tx_rfn`=1; then requester 0 is accepted.
- With `UART_TX_SCHED_FIXED_PRIO_EN` defined: `req_valid`=4'b0110 held continuously → requester 1 is always granted, requester 2 is starved.
